timer_ctrl: RTL

//  Programmable timer controller that sequences a synchronous WIDTH-bit up counter.
//  - Prescaled tick generation; compare match; one-shot/periodic modes; sticky interrupt.
//  - Small register file (CTRL/COMPARE/COUNT/STATUS) written through a simple config port.
//  - Sits beside the core as the machine-timer source feeding the interrupt controller.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_ctrl_if.sv | 30 +++
 rtl/timer_ctrl_prescale_tick.sv | 33 +++
 rtl/timer_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and register map for the machine-timer controller.
// Imported by the timer interface, the prescaler and the top.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_e;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_COMPARE = 2'd1;
  localparam logic [1:0] ADDR_COUNT   = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_PERIODIC = 0;
  localparam int CTRL_PRESC    = 8;

  localparam int STAT_IRQ  = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_EXP  = 2;

endpackage

// File: rtl/timer_ctrl_if.sv
// Config/control bundle between the core side and the timer.
// master drives requests, slave is the timer itself.
interface timer_ctrl_if #(
  parameter int WIDTH = 32
) ();

  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [31:0]      cfg_rdata;
  logic             start;
  logic             stop;
  logic             irq_ack;
  logic             irq;
  logic             busy;
  logic [WIDTH-1:0] count;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    output start, stop, irq_ack,
    input  cfg_rdata, irq, busy, count
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata,
    input  start, stop, irq_ack,
    output cfg_rdata, irq, busy, count
  );

endinterface

// File: rtl/timer_ctrl_prescale_tick.sv
// Prescale counter: tick every prescale+1 clocks while not cleared.
// presc keeps running across prescale changes and wraps naturally.
module prescale_tick #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;

  assign tick = (presc_q == prescale);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (clr || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Machine-timer controller: prescaled up counter, compare match,
// one-shot/periodic sequencing and a sticky interrupt.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  timer_ctrl_if.slave  bus
);

  timer_state_e       state_q;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   compare_q;
  logic [PRESC_W-1:0] prescale_q;
  logic               periodic_q;
  logic               irq_q;
  logic               busy_q;

  logic run;
  logic go;
  logic clr;
  logic tick;
  logic match;
  logic unused_wdata;

  assign run = (state_q == RUN);
  assign go  = bus.start & ~bus.stop;

  // presc is idle-zero outside RUN and on every stop/restart
  assign clr = ~run | bus.stop | bus.start;

  assign match = run & ~bus.stop & ~bus.start
               & tick & (count_q == compare_q);

  prescale_tick #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periodic_q <= 1'b0;
      prescale_q <= '0;
      compare_q  <= '0;
    end else if (bus.cfg_we) begin
      if (bus.cfg_addr == ADDR_CTRL) begin
        periodic_q <= bus.cfg_wdata[CTRL_PERIODIC];
        prescale_q <= bus.cfg_wdata[CTRL_PRESC +: PRESC_W];
      end
      if (bus.cfg_addr == ADDR_COMPARE) begin
        compare_q <= bus.cfg_wdata[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (match) begin
      irq_q <= 1'b1;
    end else if (bus.irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            count_q <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.start) begin
            count_q <= '0;
          end else if (tick) begin
            if (count_q != compare_q) begin
              count_q <= count_q + 1'b1;
            end else if (periodic_q) begin
              count_q <= '0;
            end else begin
              state_q <= EXPIRED;
              busy_q  <= 1'b0;
            end
          end
        end
        EXPIRED: begin
          if (bus.stop) begin
            state_q <= IDLE;
          end else if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            count_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.cfg_rdata = '0;
    unique case (bus.cfg_addr)
      ADDR_CTRL: begin
        bus.cfg_rdata[CTRL_PERIODIC] = periodic_q;
        bus.cfg_rdata[CTRL_PRESC +: PRESC_W] = prescale_q;
      end
      ADDR_COMPARE: bus.cfg_rdata = 32'(compare_q);
      ADDR_COUNT:   bus.cfg_rdata = 32'(count_q);
      ADDR_STATUS: begin
        bus.cfg_rdata[STAT_IRQ]  = irq_q;
        bus.cfg_rdata[STAT_BUSY] = busy_q;
        bus.cfg_rdata[STAT_EXP]  = (state_q == EXPIRED);
      end
      default: bus.cfg_rdata = '0;
    endcase
  end

  // only CTRL/COMPARE bits are architected; the rest are dropped
  assign unused_wdata = ^bus.cfg_wdata;

  assign bus.irq   = irq_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;

endmodule
